// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - instruction/flag inputs and datapath control outputs of mc_control
interface mc_control_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       wpc;
  logic       wir;
  logic       wmem;
  logic       wreg;
  logic       iord;
  logic       regrt;
  logic       m2reg;
  logic       jal;
  logic       sext;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [3:0] aluc;
  logic [1:0] pcsource;
  logic [2:0] state;

  // master is the datapath side (instruction register, ALU flag)
  modport master (
    output op, func, zero,
    input  wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext,
    input  alusrca, alusrcb, aluc, pcsource, state
  );

  modport slave (
    input  op, func, zero,
    output wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext,
    output alusrca, alusrcb, aluc, pcsource, state
  );
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS-subset control FSM (IF/ID/EXE/MEM/WB)
module mc_control (
  input  logic         clk,
  input  logic         clrn,
  mc_control_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  state_t cur, nxt;

  logic rtype;
  logic i_add, i_sub, i_and, i_or, i_jr;
  logic i_addi, i_ori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic i_alur, i_known;

  assign rtype  = (bus.op == 6'b000000);
  assign i_add  = rtype & (bus.func == 6'b100000);
  assign i_sub  = rtype & (bus.func == 6'b100010);
  assign i_and  = rtype & (bus.func == 6'b100100);
  assign i_or   = rtype & (bus.func == 6'b100101);
  assign i_jr   = rtype & (bus.func == 6'b001000);
  assign i_addi = (bus.op == 6'b001000);
  assign i_ori  = (bus.op == 6'b001101);
  assign i_lui  = (bus.op == 6'b001111);
  assign i_lw   = (bus.op == 6'b100011);
  assign i_sw   = (bus.op == 6'b101011);
  assign i_beq  = (bus.op == 6'b000100);
  assign i_bne  = (bus.op == 6'b000101);
  assign i_j    = (bus.op == 6'b000010);
  assign i_jal  = (bus.op == 6'b000011);

  assign i_alur  = i_add | i_sub | i_and | i_or;
  assign i_known = i_alur | i_addi | i_ori | i_lui | i_lw | i_sw | i_beq | i_bne;

  logic       wpc_c, wir_c, wmem_c, wreg_c;
  logic       iord_c, regrt_c, m2reg_c, jal_c, sext_c, alusrca_c;
  logic [1:0] alusrcb_c, pcsource_c;
  logic [3:0] aluc_c;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cur <= S_IF;
    else       cur <= nxt;
  end

  always_comb begin
    nxt        = S_IF;
    wpc_c      = 1'b0;
    wir_c      = 1'b0;
    wmem_c     = 1'b0;
    wreg_c     = 1'b0;
    iord_c     = 1'b0;
    regrt_c    = 1'b0;
    m2reg_c    = 1'b0;
    jal_c      = 1'b0;
    sext_c     = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    aluc_c     = 4'b0000;
    pcsource_c = 2'b00;
    case (cur)
      S_IF: begin
        wpc_c     = 1'b1;
        wir_c     = 1'b1;
        alusrcb_c = 2'b01;
        nxt       = S_ID;
      end
      S_ID: begin
        // branch target is precomputed here so EXE only has to compare
        alusrcb_c = 2'b11;
        sext_c    = 1'b1;
        if (i_j) begin
          wpc_c      = 1'b1;
          pcsource_c = 2'b11;
        end else if (i_jal) begin
          wpc_c      = 1'b1;
          pcsource_c = 2'b11;
          wreg_c     = 1'b1;
          jal_c      = 1'b1;
        end else if (i_jr) begin
          wpc_c      = 1'b1;
          pcsource_c = 2'b10;
        end else if (i_known) begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        alusrca_c = 1'b1;
        if (i_alur) begin
          alusrcb_c = 2'b00;
          aluc_c    = i_sub ? 4'b0100 : i_and ? 4'b0001 : i_or ? 4'b0101 : 4'b0000;
          nxt       = S_WB;
        end else if (i_addi) begin
          alusrcb_c = 2'b10;
          sext_c    = 1'b1;
          nxt       = S_WB;
        end else if (i_ori) begin
          alusrcb_c = 2'b10;
          aluc_c    = 4'b0101;
          nxt       = S_WB;
        end else if (i_lui) begin
          alusrcb_c = 2'b10;
          aluc_c    = 4'b0110;
          nxt       = S_WB;
        end else if (i_lw | i_sw) begin
          alusrcb_c = 2'b10;
          sext_c    = 1'b1;
          nxt       = S_MEM;
        end else if (i_beq | i_bne) begin
          alusrcb_c  = 2'b00;
          aluc_c     = 4'b0100;
          pcsource_c = 2'b01;
          wpc_c      = (i_beq & bus.zero) | (i_bne & ~bus.zero);
        end
      end
      S_MEM: begin
        iord_c = 1'b1;
        wmem_c = i_sw;
        if (i_lw) nxt = S_WB;
      end
      S_WB: begin
        wreg_c  = 1'b1;
        regrt_c = i_addi | i_ori | i_lui | i_lw;
        m2reg_c = i_lw;
      end
      default: nxt = S_IF;
    endcase
  end

  // reset holds state at IF; write strobes are additionally masked so nothing commits
  assign bus.wpc      = wpc_c  & clrn;
  assign bus.wir      = wir_c  & clrn;
  assign bus.wmem     = wmem_c & clrn;
  assign bus.wreg     = wreg_c & clrn;
  assign bus.iord     = iord_c;
  assign bus.regrt    = regrt_c;
  assign bus.m2reg    = m2reg_c;
  assign bus.jal      = jal_c;
  assign bus.sext     = sext_c;
  assign bus.alusrca  = alusrca_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.aluc     = aluc_c;
  assign bus.pcsource = pcsource_c;
  assign bus.state    = cur;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - randomized instruction stream against a per-instruction cycle model of mc_control
module tb_mc_control;

  logic clk;
  logic clrn;
  mc_control_if bus ();

  mc_control dut (.clk(clk), .clrn(clrn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic [2:0] state;
  } ctl_t;

  typedef struct {
    ctl_t c;
    int   br;   // 0: fixed wpc, 1: wpc=zero (beq), 2: wpc=~zero (bne)
  } exp_t;

  localparam int C_ADD = 0, C_SUB = 1, C_AND = 2, C_OR = 3, C_JR = 4, C_ADDI = 5, C_ORI = 6;
  localparam int C_LUI = 7, C_LW = 8, C_SW = 9, C_BEQ = 10, C_BNE = 11, C_J = 12, C_JAL = 13, C_NOP = 14;

  int   passed = 0;
  int   total  = 0;
  exp_t exp_q[$];
  ctl_t obs[$];
  bit   wmem_seen;

  always @(posedge clk) if (bus.wmem === 1'b1) wmem_seen = 1'b1;

  function automatic int classify(input logic [5:0] op, input logic [5:0] func);
    if (op == 6'd0) begin
      case (func)
        6'b100000: return C_ADD;
        6'b100010: return C_SUB;
        6'b100100: return C_AND;
        6'b100101: return C_OR;
        6'b001000: return C_JR;
        default:   return C_NOP;
      endcase
    end
    case (op)
      6'b001000: return C_ADDI;
      6'b001101: return C_ORI;
      6'b001111: return C_LUI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_NOP;
    endcase
  endfunction

  function automatic void push(input ctl_t c, input int br);
    exp_t e;
    e.c  = c;
    e.br = br;
    exp_q.push_back(e);
  endfunction

  // expected per-cycle control words for one whole instruction
  function automatic void build(input logic [5:0] op, input logic [5:0] func);
    int   k;
    ctl_t r;
    int   br;
    k = classify(op, func);
    r = '0; r.wpc = 1; r.wir = 1; r.alusrcb = 2'b01; r.state = 3'd0;
    push(r, 0);
    r = '0; r.state = 3'd1; r.alusrcb = 2'b11; r.sext = 1;
    if (k == C_J || k == C_JAL) begin r.wpc = 1; r.pcsource = 2'b11; end
    if (k == C_JAL) begin r.wreg = 1; r.jal = 1; end
    if (k == C_JR) begin r.wpc = 1; r.pcsource = 2'b10; end
    push(r, 0);
    if (k == C_J || k == C_JAL || k == C_JR || k == C_NOP) return;
    r = '0; r.state = 3'd2; r.alusrca = 1; br = 0;
    case (k)
      C_ADD, C_SUB, C_AND, C_OR: begin
        r.alusrcb = 2'b00;
        r.aluc = (k == C_SUB) ? 4'b0100 : (k == C_AND) ? 4'b0001 : (k == C_OR) ? 4'b0101 : 4'b0000;
      end
      C_ADDI:      begin r.alusrcb = 2'b10; r.sext = 1; end
      C_ORI:       begin r.alusrcb = 2'b10; r.aluc = 4'b0101; end
      C_LUI:       begin r.alusrcb = 2'b10; r.aluc = 4'b0110; end
      C_LW, C_SW:  begin r.alusrcb = 2'b10; r.sext = 1; end
      default: begin
        r.aluc = 4'b0100; r.pcsource = 2'b01;
        br = (k == C_BEQ) ? 1 : 2;
      end
    endcase
    push(r, br);
    if (k == C_BEQ || k == C_BNE) return;
    if (k == C_LW || k == C_SW) begin
      r = '0; r.state = 3'd3; r.iord = 1; r.wmem = (k == C_SW);
      push(r, 0);
      if (k == C_SW) return;
    end
    r = '0; r.state = 3'd4; r.wreg = 1;
    r.regrt = (k == C_ADDI || k == C_ORI || k == C_LUI || k == C_LW);
    r.m2reg = (k == C_LW);
    push(r, 0);
  endfunction

  function automatic ctl_t sample();
    return {bus.wpc, bus.wir, bus.wmem, bus.wreg, bus.iord, bus.regrt, bus.m2reg, bus.jal,
            bus.sext, bus.alusrca, bus.alusrcb, bus.aluc, bus.pcsource, bus.state};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_zero(input int zmode);
    bus.zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
  endtask

  // runs one instruction from IF; stop>0 leaves the bench at the negedge of that cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input int zmode, input int stop);
    exp_t e;
    ctl_t s;
    int   n;
    bus.op   = op;
    bus.func = func;
    set_zero(zmode);
    exp_q.delete();
    obs.delete();
    build(op, func);
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      if (e.br == 1) e.c.wpc = bus.zero;
      if (e.br == 2) e.c.wpc = ~bus.zero;
      s = sample();
      obs.push_back(s);
      check($sformatf("cycle%0d op=%b func=%b", n, op, func), 32'(s), 32'(e.c));
      n++;
      if (stop > 0 && n == stop) return;
      @(posedge clk);
      #1;
      set_zero(zmode);
    end
  endtask

  logic [5:0] tbl_op   [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'b001000, 6'b001101,
                                6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011};
  logic [5:0] tbl_func [14] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b001000, 6'd0, 6'd0,
                                6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

  ctl_t rst_exp;

  initial begin
    clrn     = 1'b0;
    bus.op   = 6'b100011;
    bus.func = 6'd0;
    bus.zero = 1'b0;
    rst_exp = '0; rst_exp.alusrcb = 2'b01;
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", 32'(sample()), 32'(rst_exp));
    end
    @(posedge clk);
    #1 clrn = 1'b1;

    run_instr(6'b100011, 6'd0, -1, 0);
    check("lw_states", {obs[0].state, obs[1].state, obs[2].state, obs[3].state, obs[4].state}, 15'b000_001_010_011_100);
    check("lw_mem_iord", obs[3].iord, 1);
    check("lw_wb_wreg_m2reg_regrt", {obs[4].wreg, obs[4].m2reg, obs[4].regrt}, 3'b111);
    check("lw_back_to_if", bus.state, 3'b000);

    run_instr(6'b000100, 6'd0, 1, 0);
    check("beq_taken", {obs[2].wpc, obs[2].pcsource}, 3'b1_01);
    check("beq_taken_len", obs.size(), 3);
    check("beq_taken_to_if", bus.state, 3'b000);
    run_instr(6'b000100, 6'd0, 0, 0);
    check("beq_not_taken", {obs[2].wpc, obs[2].pcsource}, 3'b0_01);
    check("beq_not_taken_to_if", bus.state, 3'b000);

    run_instr(6'b000011, 6'd0, -1, 0);
    check("jal_id", {obs[1].wpc, obs[1].pcsource, obs[1].wreg, obs[1].jal}, 5'b1_11_1_1);
    check("jal_to_if", bus.state, 3'b000);

    run_instr(6'b000000, 6'b100010, -1, 0);
    check("sub_exe", {obs[2].aluc, obs[2].alusrca, obs[2].alusrcb}, 7'b0100_1_00);
    check("sub_wb", {obs[3].wreg, obs[3].regrt}, 2'b10);

    run_instr(6'b111111, 6'b111111, -1, 0);
    check("nop_len", obs.size(), 2);
    check("nop_writes", {obs[0].wreg, obs[0].wmem, obs[1].wreg, obs[1].wmem, obs[1].wpc}, 5'b0);
    check("nop_to_if", bus.state, 3'b000);

    // sw aborted by reset in EXE
    run_instr(6'b101011, 6'd0, -1, 3);
    wmem_seen = 1'b0;
    #2 clrn = 1'b0;
    #1;
    check("abort_async_state", bus.state, 3'b000);
    check("abort_writes", {bus.wpc, bus.wir, bus.wmem, bus.wreg}, 4'b0);
    @(posedge clk);
    #1;
    check("abort_held_state", bus.state, 3'b000);
    clrn = 1'b1;
    check("abort_no_wmem", wmem_seen, 0);
    run_instr(6'b101011, 6'd0, -1, 0);
    check("after_abort_if_write", {obs[0].wpc, obs[0].wir}, 2'b11);

    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 15);
      if (sel < 14)       run_instr(tbl_op[sel], tbl_func[sel], -1, 0);
      else if (sel == 14) run_instr(6'($urandom), 6'($urandom), -1, 0);
      else                run_instr(6'd0, 6'($urandom), -1, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
